// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states
// and the sign/boundary fix-up record latched at launch.
package muldiv_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // Post-processing applied to the unsigned core result when the op retires
  typedef struct packed {
    logic is_div;
    logic neg_hi;
    logic neg_lo;
    logic div0;
  } md_fix_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, busA, busB, hi_we, lo_we,
    input  hi_out, lo_out, busy, done
  );

  modport slave (
    input  start, op, busA, busB, hi_we, lo_we,
    output hi_out, lo_out, busy, done
  );

endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit
// per cycle, with the iteration counter. Exposes the next-step result combinationally.
module muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] nxt_hi_c,
  output logic [WIDTH-1:0] nxt_lo_c,
  output logic             last_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   sh_c;
  logic             ge_c;

  // Multiply: hi=partial product, lo=multiplier; divide: hi=remainder, lo=dividend/quotient
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= is_div ? opa : opb;
      d_q   <= is_div ? opb : opa;
      cnt_q <= '0;
      div_q <= is_div;
    end else if (run) begin
      hi_q  <= nxt_hi_c;
      lo_q  <= nxt_lo_c;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    sum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    sh_c     = {hi_q, lo_q[WIDTH-1]};
    ge_c     = (sh_c >= {1'b0, d_q});
    nxt_hi_c = sum_c[WIDTH:1];
    nxt_lo_c = {sum_c[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      // Remainder never exceeds WIDTH bits, including the divide-by-zero case
      nxt_hi_c = ge_c ? WIDTH'(sh_c - {1'b0, d_q}) : sh_c[WIDTH-1:0];
      nxt_lo_c = {lo_q[WIDTH-2:0], ge_c};
    end
  end

  assign last_c = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO. Handles sign
// magnitudes, FSM and HI/LO; the unsigned iteration lives in muldiv_core.
module muldiv_unit
  import muldiv_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  md_state_e        state_q, state_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  md_fix_t          fix_q, fix_c;
  logic [WIDTH-1:0] a_raw_q;

  logic             load_c;
  logic             run_c;
  logic             is_div_c;
  logic             signed_c;
  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH-1:0] core_hi_c;
  logic [WIDTH-1:0] core_lo_c;
  logic             core_last_c;
  logic [2*WIDTH-1:0] prod_c;

  // Launch-time decode: magnitudes into the core, sign fix-up recorded for retirement
  always_comb begin
    is_div_c = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
    signed_c = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    sa_c     = signed_c & bus.busA[WIDTH-1];
    sb_c     = signed_c & bus.busB[WIDTH-1];
    mag_a_c  = sa_c ? -bus.busA : bus.busA;
    mag_b_c  = sb_c ? -bus.busB : bus.busB;
    fix_c.is_div = is_div_c;
    fix_c.div0   = is_div_c && (bus.busB == '0);
    fix_c.neg_lo = sa_c ^ sb_c;
    fix_c.neg_hi = is_div_c ? sa_c : (sa_c ^ sb_c);
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (load_c),
    .run      (run_c),
    .is_div   (is_div_c),
    .opa      (mag_a_c),
    .opb      (mag_b_c),
    .nxt_hi_c (core_hi_c),
    .nxt_lo_c (core_lo_c),
    .last_c   (core_last_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      fix_q   <= '0;
      a_raw_q <= '0;
    end else begin
      state_q <= state_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      if (load_c) begin
        fix_q   <= fix_c;
        a_raw_q <= bus.busA;
      end
    end
  end

  // Next state, HI/LO update and retirement fix-up
  always_comb begin
    state_n = state_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    load_c  = 1'b0;
    run_c   = 1'b0;
    prod_c  = {core_hi_c, core_lo_c};
    if (fix_q.neg_hi) begin
      prod_c = -prod_c;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          busy_n  = 1'b1;
          state_n = S_RUN;
        end else begin
          if (bus.hi_we) hi_n = bus.busA;
          if (bus.lo_we) lo_n = bus.busA;
        end
      end
      S_RUN: begin
        run_c  = 1'b1;
        busy_n = 1'b1;
        if (core_last_c) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          if (!fix_q.is_div) begin
            {hi_n, lo_n} = prod_c;
          end else if (fix_q.div0) begin
            hi_n = a_raw_q;
            lo_n = '1;
          end else begin
            lo_n = fix_q.neg_lo ? -core_lo_c : core_lo_c;
            hi_n = fix_q.neg_hi ? -core_hi_c : core_hi_c;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency,
// busy protection, idle MTHI/MTLO, mid-op reset and back-to-back issue.
module tb_muldiv_unit;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.busA  = a;
    bus.busB  = b;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Called just after the launch edge; returns edges until done and busy samples seen
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busy_cycles++;
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.hi_out, bus.lo_out, bus.busy, bus.done} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want all zero",
               bus.hi_out, bus.lo_out, bus.busy, bus.done);
    end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int cyc, bcyc;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      errors++;
      $display("FAIL multu_hold: got hi=%h lo=%h want 0/0 while running", bus.hi_out, bus.lo_out);
    end
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 32 || bcyc !== 32) begin
      errors++;
      $display("FAIL multu_latency: got done_after=%0d busy_cycles=%0d want 32/32", cyc, bcyc);
    end
    checks++;
    if (bus.hi_out !== 32'hFFFF_FFFE || bus.lo_out !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_result: got hi=%h lo=%h want FFFFFFFE/00000001", bus.hi_out, bus.lo_out);
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL multu_done_pulse: got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_mult();
    int cyc, bcyc;
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 32 || bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_signed: got cyc=%0d hi=%h lo=%h want 32 FFFFFFFF/FFFFFFEB", cyc, bus.hi_out, bus.lo_out);
    end
  endtask

  task automatic test_div();
    int cyc, bcyc;
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 32 || bus.lo_out !== 32'hFFFF_FFFD || bus.hi_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_signed: got cyc=%0d lo=%h hi=%h want 32 FFFFFFFD/FFFFFFFF", cyc, bus.lo_out, bus.hi_out);
    end
    issue(2'b11, 32'h0000_0064, 32'h0000_0007);
    wait_done(cyc, bcyc);
    checks++;
    if (bus.lo_out !== 32'h0000_000E || bus.hi_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL divu_basic: got lo=%h hi=%h want 0000000E/00000002", bus.lo_out, bus.hi_out);
    end
    issue(2'b11, 32'h0000_0007, 32'h0000_0000);
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 32 || bus.lo_out !== 32'hFFFF_FFFF || bus.hi_out !== 32'h0000_0007) begin
      errors++;
      $display("FAIL divu_by_zero: got cyc=%0d lo=%h hi=%h want 32 FFFFFFFF/00000007", cyc, bus.lo_out, bus.hi_out);
    end
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
    wait_done(cyc, bcyc);
    checks++;
    if (bus.lo_out !== 32'hFFFF_FFFF || bus.hi_out !== 32'hFFFF_FFF9) begin
      errors++;
      $display("FAIL div_by_zero: got lo=%h hi=%h want FFFFFFFF/FFFFFFF9", bus.lo_out, bus.hi_out);
    end
  endtask

  task automatic test_div_overflow();
    int cyc, bcyc;
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bcyc);
    checks++;
    if (bus.lo_out !== 32'h8000_0000 || bus.hi_out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL div_most_negative: got lo=%h hi=%h want 80000000/00000000", bus.lo_out, bus.hi_out);
    end
  endtask

  task automatic test_busy_protect();
    int cyc, bcyc;
    issue(2'b01, 32'h0000_0003, 32'h0000_0005);
    repeat (4) @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.busA  = 32'hAAAA_5555;
    bus.busB  = 32'h0000_0000;
    bus.hi_we = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    checks++;
    if (bus.hi_out !== 32'h0000_0000 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_hi_we: got hi=%h busy=%b want 00000000/1", bus.hi_out, bus.busy);
    end
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 27 || bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0000_000F) begin
      errors++;
      $display("FAIL busy_start_ignored: got rem_cyc=%0d hi=%h lo=%h want 27 00000000/0000000F", cyc, bus.hi_out, bus.lo_out);
    end
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_not_queued: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_idle_write();
    @(negedge clock);
    bus.busA  = 32'h1234_5678;
    bus.hi_we = 1'b1;
    @(negedge clock);
    bus.hi_we = 1'b0;
    checks++;
    if (bus.hi_out !== 32'h1234_5678 || bus.lo_out !== 32'h0000_000F) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h want 12345678/0000000F", bus.hi_out, bus.lo_out);
    end
    bus.busA  = 32'hCAFE_F00D;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    @(negedge clock);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checks++;
    if (bus.hi_out !== 32'hCAFE_F00D || bus.lo_out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h want CAFEF00D/CAFEF00D", bus.hi_out, bus.lo_out);
    end
    // start and writes together: start wins, writes dropped
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.busA  = 32'h0000_0002;
    bus.busB  = 32'h0000_0003;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.hi_out !== 32'hCAFE_F00D || bus.lo_out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL start_wins: got busy=%b hi=%h lo=%h want 1 CAFEF00D/CAFEF00D", bus.busy, bus.hi_out, bus.lo_out);
    end
  endtask

  task automatic test_reset_midop();
    int cyc, bcyc;
    wait_done(cyc, bcyc);
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0000_0006) begin
      errors++;
      $display("FAIL multu_2x3: got hi=%h lo=%h want 00000000/00000006", bus.hi_out, bus.lo_out);
    end
    issue(2'b00, 32'h0000_0005, 32'h0000_0006);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_midop: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi_out, bus.lo_out);
    end
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done || bus.busy || bus.lo_out != 32'h0) cyc++;
    end
    checks++;
    if (cyc !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    issue(2'b11, 32'h0000_0064, 32'h0000_0007);
    wait_done(cyc, bcyc);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.busA  = 32'h0000_0006;
    bus.busB  = 32'h0000_0007;
    @(negedge clock);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.lo_out !== 32'h0000_000E || bus.hi_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b hi=%h lo=%h want 1 00000002/0000000E", bus.busy, bus.hi_out, bus.lo_out);
    end
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 32 || bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0000_002A) begin
      errors++;
      $display("FAIL b2b_result: got cyc=%0d hi=%h lo=%h want 32 00000000/0000002A", cyc, bus.hi_out, bus.lo_out);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.busA  = '0;
    bus.busB  = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_overflow();
    test_busy_protect();
    test_idle_write();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
